// File: rtl/lz_scan_ctrl_if.sv
// Bundle of the command, word-stream and result signals of lz_scan_ctrl.
// Both streams use the same rule: a transfer happens on a rising edge where
// the producer's valid and the consumer's ready are both high. The producer
// holds its payload steady until that edge, and ready never depends on valid.
interface lz_scan_ctrl_if;
    // command
    logic        start;
    logic [4:0]  word_count;
    // operand word stream (bench -> block)
    logic [31:0] data;
    logic        valid;
    logic        ready;
    // result stream (block -> bench)
    logic [9:0]  total_zero;
    logic        all_zero;
    logic [3:0]  first_index;
    logic        res_valid;
    logic        res_ready;
    // status and debug
    logic        busy;
    logic        error;
    logic [1:0]  state;

    modport master (
        output start, word_count, data, valid, res_ready,
        input  ready, total_zero, all_zero, first_index, res_valid, busy, error, state
    );

    modport slave (
        input  start, word_count, data, valid, res_ready,
        output ready, total_zero, all_zero, first_index, res_valid, busy, error, state
    );
endinterface

// File: rtl/lz_scan_ctrl.sv
// Leading-zero scanner for a multi-word operand delivered most-significant
// word first. The operand's leading zeros are summed until the first
// nonzero word; the remaining words are drained without being counted.
module lz_scan_ctrl #(
    parameter int MAX_WORDS = 16
) (
    input  logic          clk,
    input  logic          rst,
    lz_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [5:0] MAX_LEN = 6'(MAX_WORDS);

    state_t      state_q;
    state_t      state_d;
    logic [9:0]  acc;
    logic        found;
    logic [3:0]  first_idx;
    logic [4:0]  cnt;
    logic [4:0]  len;
    logic        error_q;

    logic        accepting;
    logic        xfer;
    logic        last_word;
    logic        word_nz;
    logic        cmd_legal;
    logic        cmd_bad;
    logic [5:0]  lzc;

    assign accepting = (state_q == SCAN) || (state_q == DRAIN);
    assign xfer      = bus.valid && accepting;
    assign last_word = (cnt == len - 5'd1);
    assign word_nz   = (bus.data != 32'd0);
    assign cmd_legal = (bus.word_count != 5'd0) && ({1'b0, bus.word_count} <= MAX_LEN);
    assign cmd_bad   = (state_q == IDLE) && bus.start && !cmd_legal;

    // Per-word leading-zero count from bit 31; the highest set bit wins, 32 when the word is zero.
    always_comb begin
        lzc = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (bus.data[i]) begin
                lzc = 6'(31 - i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: scan until the first nonzero word, drain the rest, hold the result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start && cmd_legal) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (xfer) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else if (word_nz) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer && last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: accumulator, found flag, first index, word counter, latched length and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 10'd0;
            found     <= 1'b0;
            first_idx <= 4'd0;
            cnt       <= 5'd0;
            len       <= 5'd0;
            error_q   <= 1'b0;
        end else begin
            error_q <= cmd_bad;
            case (state_q)
                IDLE: begin
                    if (bus.start && cmd_legal) begin
                        acc       <= 10'd0;
                        found     <= 1'b0;
                        first_idx <= 4'd0;
                        cnt       <= 5'd0;
                        len       <= bus.word_count;
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        // SCAN is left on the first nonzero word, so found is
                        // still clear here and this is the first one seen.
                        acc <= acc + {4'd0, lzc};
                        cnt <= cnt + 5'd1;
                        if (word_nz) begin
                            found     <= 1'b1;
                            first_idx <= cnt[3:0];
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs come from registers only; all_zero reads as 0 outside DONE
    // so it matches its reset value while no result is presented.
    assign bus.ready       = accepting;
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.error       = error_q;
    assign bus.total_zero  = acc;
    assign bus.all_zero    = (state_q == DONE) && !found;
    assign bus.first_index = first_idx;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_lz_scan_ctrl.sv
// Directed bench for lz_scan_ctrl: stimulus pushes expected results into a
// queue, a separate monitor compares them whenever a result is presented.
module tb_lz_scan_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lz_scan_ctrl_if bus ();

    lz_scan_ctrl #(.MAX_WORDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    // packed expected result: {total_zero[9:0], all_zero, first_index[3:0]}
    logic [14:0] exp_q[$];
    int   cyc       = 0;
    int   scan_cyc  = 0;
    int   exp_lat   = -1;
    logic ready_prev = 1'b0;
    logic valid_prev = 1'b0;
    logic [1:0]  st;
    logic [31:0] words4 [4];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [14:0] e;
        if (!rst) begin
            if (bus.ready && !ready_prev) begin
                scan_cyc = cyc;
            end
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_result");
                end else begin
                    e = exp_q[0];
                    // cycles counted inclusively from the first SCAN cycle to the first valid cycle
                    if (!valid_prev && exp_lat >= 0) begin
                        check("latency", 32'(cyc - scan_cyc + 1), 32'(exp_lat));
                        exp_lat = -1;
                    end
                    check("total_zero", 32'(bus.total_zero), 32'(e[14:5]));
                    check("all_zero", 32'(bus.all_zero), 32'(e[4]));
                    check("first_index", 32'(bus.first_index), 32'(e[3:0]));
                    if (bus.res_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        ready_prev = bus.ready;
        valid_prev = bus.res_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input logic [4:0] n);
        bus.start      = 1'b1;
        bus.word_count = n;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int max_gap, output logic [1:0] state_at);
        int   n;
        logic got;
        state_at = 2'd0;
        repeat ($urandom_range(max_gap, 0)) begin
            bus.valid = 1'b0;
            bus.data  = $urandom;
            @(posedge clk);
            #1;
        end
        bus.valid = 1'b1;
        bus.data  = d;
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            got      = bus.ready;
            state_at = bus.state;
            @(posedge clk);
            #1;
            n++;
        end
        bus.valid = 1'b0;
        if (!got) flag_fail("send_word_timeout");
    endtask

    task automatic wait_result();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 100);
        if (!bus.res_valid) flag_fail("wait_result_timeout");
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 200);
        if (bus.busy) flag_fail("wait_idle_timeout");
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.start      = 1'b0;
        bus.word_count = 5'd0;
        bus.data       = 32'd0;
        bus.valid      = 1'b0;
        bus.res_ready  = 1'b1;
        rst            = 1'b1;
        repeat (3) @(posedge clk);

        // reset state
        @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_total_zero", 32'(bus.total_zero), 32'd0);
        check("rst_all_zero", 32'(bus.all_zero), 32'd0);
        check("rst_first_index", 32'(bus.first_index), 32'd0);
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;

        // one word 0x0000_0F00: highest set bit 11 -> 20 zeros
        exp_q.push_back({10'd20, 1'b0, 4'd0});
        exp_lat = 2;
        start_cmd(5'd1);
        send_word(32'h0000_0F00, 0, st);
        check("t1_accept_state", 32'(st), 32'(ST_SCAN));
        wait_idle();

        // four words: 32 + 32 + 31 = 95, first nonzero at index 2, last word drained
        words4[0] = 32'h0000_0000;
        words4[1] = 32'h0000_0000;
        words4[2] = 32'h0000_0001;
        words4[3] = 32'hFFFF_FFFF;
        exp_q.push_back({10'd95, 1'b0, 4'd2});
        exp_lat = 5;
        start_cmd(5'd4);
        for (int i = 0; i < 4; i++) begin
            send_word(words4[i], 0, st);
            if (i == 2) check("t2_word2_state", 32'(st), 32'(ST_SCAN));
            if (i == 3) check("t2_word3_state", 32'(st), 32'(ST_DRAIN));
        end
        wait_idle();

        // sixteen zero words: 16 x 32 = 512, all zero
        exp_q.push_back({10'd512, 1'b1, 4'd0});
        start_cmd(5'd16);
        for (int i = 0; i < 16; i++) begin
            send_word(32'd0, 0, st);
        end
        wait_idle();

        // illegal lengths 0 and 17: one error pulse each, never busy or ready
        for (int k = 0; k < 2; k++) begin
            start_cmd((k == 0) ? 5'd0 : 5'd17);
            @(negedge clk);
            check("err_pulse", 32'(bus.error), 32'd1);
            check("err_busy", 32'(bus.busy), 32'd0);
            check("err_ready", 32'(bus.ready), 32'd0);
            repeat (3) begin
                @(negedge clk);
                check("err_pulse_end", 32'(bus.error), 32'd0);
                check("err_ready_low", 32'(bus.ready), 32'd0);
                check("err_busy_low", 32'(bus.busy), 32'd0);
            end
        end

        // random valid gaps, result held for 5 cycles: 32 + 8 = 40, first index 1
        bus.res_ready = 1'b0;
        exp_q.push_back({10'd40, 1'b0, 4'd1});
        start_cmd(5'd3);
        send_word(32'h0000_0000, 3, st);
        send_word(32'h00F0_0000, 3, st);
        send_word(32'h0000_FFFF, 3, st);
        wait_result();
        repeat (5) begin
            @(negedge clk);
            check("hold_state", 32'(bus.state), 32'(ST_DONE));
        end
        @(posedge clk);
        #1;
        bus.res_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.word_count = 5'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("post_handshake_busy", 32'(bus.busy), 32'd0);
        check("post_handshake_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("start_in_handshake_ignored", 32'(bus.state), 32'(ST_IDLE));

        // reset after two of four words, then a fresh one-word command
        start_cmd(5'd4);
        send_word(32'h0000_0000, 0, st);
        send_word(32'h0000_0005, 0, st);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.ready), 32'd0);
        check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_error", 32'(bus.error), 32'd0);
        check("mid_rst_total_zero", 32'(bus.total_zero), 32'd0);
        check("mid_rst_all_zero", 32'(bus.all_zero), 32'd0);
        check("mid_rst_first_index", 32'(bus.first_index), 32'd0);
        @(posedge clk);
        #1;
        bus.valid = 1'b1;
        bus.data  = 32'h1234_5678;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_not_ready", 32'(bus.ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.valid = 1'b0;
        exp_q.push_back({10'd0, 1'b0, 4'd0});
        start_cmd(5'd1);
        send_word(32'h8000_0000, 0, st);
        wait_idle();

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lz_scan_ctrl.md
LZ_SCAN_CTRL -- requirements
Module: lz_scan_ctrl

Interface
REQ-001 Parameter: MAX_WORDS, 16, largest operand length in 32-bit words accepted per command.
REQ-002 iClk  input  1  single clock; all state changes on rising edge.
REQ-003 iReset  input  1  reset; synchronous, active-high.
REQ-004 iStart  input  1  command strobe; sampled only in IDLE.
REQ-005 iWordCount  input  5  operand length in words, captured with iStart; legal range 1..MAX_WORDS.
REQ-006 iData  input  32  operand word, most-significant word first.
REQ-007 iValid  input  1  iData valid; a word transfers when iValid and oReady are both high.
REQ-008 oReady  output  1  block accepts a word this cycle.
REQ-009 oTotalZero  output  10  leading-zero count of the whole operand, 0..512.
REQ-010 oAllZero  output  1  every word of the operand was zero.
REQ-011 oFirstIndex  output  4  index (0 = first word received) of the first nonzero word; 0 when oAllZero.
REQ-012 oValid  output  1  result outputs valid.
REQ-013 iReady  input  1  consumer accepts the result when oValid and iReady are both high.
REQ-014 oBusy  output  1  high in every state except IDLE.
REQ-015 oError  output  1  one-cycle pulse on an illegal command.

Function
REQ-016 The block SHALL implement states IDLE, SCAN, DRAIN, DONE, encoded in a registered state variable.
REQ-017 The block SHALL compute the per-word count as the number of leading zeros of iData starting from bit 31, giving 32 for an all-zero word.
REQ-018 In IDLE, iStart with iWordCount in 1..MAX_WORDS SHALL clear the accumulator, found flag and word counter, latch the length, and move to SCAN on the next edge.
REQ-019 In IDLE, iStart with iWordCount = 0 or > MAX_WORDS SHALL pulse oError for exactly one cycle and keep the state IDLE.
REQ-020 iStart outside IDLE SHALL be ignored; no error and no state change.
REQ-021 oReady SHALL be high exactly in SCAN and DRAIN, and low in IDLE and DONE.
REQ-022 In SCAN, each accepted word SHALL add its per-word count to the accumulator (10-bit, no overflow possible).
REQ-023 In SCAN, the first accepted nonzero word SHALL set the found flag and record its index in oFirstIndex.
REQ-024 After the first nonzero word, the next state SHALL be DRAIN if words remain, otherwise DONE.
REQ-025 In DRAIN, accepted words SHALL be consumed without changing the accumulator, found flag or oFirstIndex.
REQ-026 Acceptance of the last word (counter = latched length - 1) SHALL move to DONE from either SCAN or DRAIN.
REQ-027 Cycles with iValid low SHALL hold all state; there are no timeouts.
REQ-028 In DONE, oValid SHALL be high and oTotalZero, oAllZero and oFirstIndex SHALL be stable until the cycle of the oValid and iReady handshake.
REQ-029 After the result handshake, the next state SHALL be IDLE; an iStart in that handshake cycle SHALL be ignored.
REQ-030 Latency: oValid SHALL rise on the first edge after the last word is accepted, so that one operand of N words takes N + 1 cycles minimum from the SCAN entry.
REQ-031 oAllZero SHALL equal NOT found flag, and oTotalZero SHALL equal 32 x N when oAllZero is high.
REQ-032 Result outputs SHALL be registered, with no combinational path from iData to any output.

Reset
REQ-033 While iReset is high at an edge, the state SHALL become IDLE, and the accumulator, word counter, found flag and latched length SHALL be cleared.
REQ-034 Reset values SHALL be: oReady=0, oValid=0, oBusy=0, oError=0, oTotalZero=0, oAllZero=0, oFirstIndex=0.
REQ-035 Reset mid-operation, in SCAN, DRAIN or DONE, SHALL abandon the operand with no oValid and no oError; words presented afterwards are not consumed until a new iStart.

Verification
REQ-036 The bench SHALL cover: iWordCount=1, word 0x0000_0F00 -> oValid 2 cycles after SCAN entry, oTotalZero=20, oAllZero=0, oFirstIndex=0.
REQ-037 The bench SHALL cover: iWordCount=4, words 0, 0, 0x0000_0001, 0xFFFF_FFFF -> oTotalZero=95, oFirstIndex=2, and the 4th word consumed in DRAIN.
REQ-038 The bench SHALL cover: iWordCount=16, all words zero -> oTotalZero=512, oAllZero=1, oFirstIndex=0.
REQ-039 The bench SHALL cover: iWordCount=0 and then 17 -> one oError pulse each, oBusy stays 0, and oReady never rises.
REQ-040 The bench SHALL cover: iValid toggled randomly and iReady held low for 5 cycles in DONE -> results unchanged, and IDLE entered the cycle after iReady rises.
REQ-041 The bench SHALL cover: iReset asserted after 2 of 4 words -> all outputs at reset values next cycle, then a new 1-word command completes correctly.
